// File: rtl/risc_v_pkg.sv
// Shared encodings and widths for the memory arbiter.
package risc_v_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single fixed-latency memory, one access outstanding.
// Valid/ready: a request is taken in the cycle its gnt is 1; rvalid pulses one cycle with rdata.
module mem_arbiter
  import risc_v_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [BE_W-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy,
  output logic [1:0]      dbg_owner
);

  state_t     state;
  owner_t     owner;
  logic [2:0] cnt;
  logic [3:0] d_streak;
  logic       store_q;
  logic       grant_i;
  logic       grant_d;

  // Grant is combinational so the access starts in the request cycle; reset masks it.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst && state == ST_IDLE) begin
      if (i_req && (!d_req || d_streak == 4'(MAX_D_STREAK))) grant_i = 1'b1;
      else if (d_req)                                         grant_d = 1'b1;
    end
  end

  assign i_gnt     = grant_i;
  assign d_gnt     = grant_d;
  assign mem_en    = grant_i | grant_d;
  assign mem_we    = grant_d & d_we;
  assign mem_addr  = grant_i ? i_addr : (grant_d ? d_addr : '0);
  assign mem_wdata = grant_d ? d_wdata : '0;
  assign mem_be    = grant_i ? {BE_W{1'b1}} : (grant_d ? d_be : '0);
  assign busy      = (state == ST_WAIT);
  assign dbg_owner = owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= OWN_NONE;
      cnt      <= 3'd0;
      d_streak <= 4'd0;
      store_q  <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;

      // Streak only counts data wins that actually kept a fetch waiting.
      if (!i_req || grant_i)                             d_streak <= 4'd0;
      else if (grant_d && d_streak < 4'(MAX_D_STREAK))   d_streak <= d_streak + 4'd1;

      case (state)
        ST_IDLE: begin
          if (grant_i || grant_d) begin
            state   <= ST_WAIT;
            owner   <= grant_i ? OWN_I : OWN_D;
            store_q <= grant_d & d_we;
            cnt     <= 3'd1;
          end
        end
        ST_WAIT: begin
          if (cnt == 3'(MEM_LAT)) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
            cnt   <= 3'd0;
            if (owner == OWN_I) begin
              i_rvalid <= 1'b1;
              i_rdata  <= mem_rdata;
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= store_q ? '0 : mem_rdata;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=1 instance for function, MEM_LAT=3 instance for reset abort.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rst3;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;

  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  dbg_owner;

  logic        i_gnt_3, i_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3, mem_we_3, busy_3;
  logic [31:0] i_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
  logic [3:0]  mem_be_3;
  logic [1:0]  dbg_owner_3;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  mem_arbiter #(.MEM_LAT(1), .MAX_D_STREAK(4)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy), .dbg_owner(dbg_owner)
  );

  mem_arbiter #(.MEM_LAT(3), .MAX_D_STREAK(4)) u_dut3 (
    .clk(clk), .rst(rst3),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_3), .i_rvalid(i_rvalid_3), .i_rdata(i_rdata_3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_be(mem_be_3), .mem_rdata(mem_rdata_3), .busy(busy_3), .dbg_owner(dbg_owner_3)
  );

  // ---------------- memory models ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0293;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Non-read cycles return junk so a wrong capture cycle is visible.
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  always @(posedge clk) begin
    pipe1    <= (mem_en && !mem_we) ? mem_word(mem_addr) : 32'hBAD0_BAD0;
    pipe3[0] <= (mem_en_3 && !mem_we_3) ? mem_word(mem_addr_3) : 32'hBAD3_BAD3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata   = pipe1;
  assign mem_rdata_3 = pipe3[2];

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic        egi;
    logic        egd;
    logic        ewe;
    logic [3:0]  ebe;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [1:0]  eown;
    logic [31:0] erdata;
  } vec_t;

  vec_t vecs[6];
  logic [1:0] exp_q[$];
  logic [1:0] got;
  logic [1:0] e;

  initial begin
    //          ireq iaddr  dreq dwe daddr    dwdata        dbe    egi egd ewe ebe    eaddr    ewdata        eown   erdata
    vecs[0] = '{1, 32'h10,  0, 0, 32'h0,    32'h0,        4'h0,  1, 0, 0, 4'hF,  32'h10,   32'h0,        2'b01, 32'h0050_0293};
    vecs[1] = '{0, 32'h0,   1, 0, 32'h40,   32'h1111_1111, 4'hF, 0, 1, 0, 4'hF,  32'h40,   32'h1111_1111, 2'b10, 32'h0040_FFBF};
    vecs[2] = '{1, 32'h80,  1, 0, 32'h1234, 32'h0,        4'hF,  0, 1, 0, 4'hF,  32'h1234, 32'h0,        2'b10, 32'h1234_EDCB};
    vecs[3] = '{0, 32'h0,   1, 1, 32'h100,  32'hDEAD_BEEF, 4'h3, 0, 1, 1, 4'h3,  32'h100,  32'hDEAD_BEEF, 2'b10, 32'h0};
    vecs[4] = '{0, 32'h0,   1, 1, 32'h104,  32'h1234_5678, 4'h0, 0, 1, 1, 4'h0,  32'h104,  32'h1234_5678, 2'b10, 32'h0};
    vecs[5] = '{1, 32'h80,  0, 0, 32'h0,    32'h0,        4'h0,  1, 0, 0, 4'hF,  32'h80,   32'h0,        2'b01, 32'h0080_FF7F};

    // ---------------- reset ----------------
    rst = 1; rst3 = 1;
    idle_inputs();
    i_req = 1; d_req = 1; d_addr = 32'h40; i_addr = 32'h10;
    wait_cycles(2);
    #1;
    chk("rst i_gnt", i_gnt, 0);
    chk("rst d_gnt", d_gnt, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst busy", busy, 0);
    chk("rst dbg_owner", dbg_owner, 0);
    chk("rst i_rvalid", i_rvalid, 0);
    chk("rst d_rdata", d_rdata, 0);
    @(negedge clk);
    idle_inputs();
    rst = 0; rst3 = 0;
    wait_cycles(2);

    // ---------------- single-access table ----------------
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      i_req = vecs[v].ireq; i_addr = vecs[v].iaddr;
      d_req = vecs[v].dreq; d_we = vecs[v].dwe; d_addr = vecs[v].daddr;
      d_wdata = vecs[v].dwdata; d_be = vecs[v].dbe;
      #1;
      chk($sformatf("v%0d i_gnt", v), i_gnt, vecs[v].egi);
      chk($sformatf("v%0d d_gnt", v), d_gnt, vecs[v].egd);
      chk($sformatf("v%0d mem_en", v), mem_en, 1);
      chk($sformatf("v%0d mem_we", v), mem_we, vecs[v].ewe);
      chk($sformatf("v%0d mem_be", v), mem_be, vecs[v].ebe);
      chk($sformatf("v%0d mem_addr", v), mem_addr, vecs[v].eaddr);
      chk($sformatf("v%0d mem_wdata", v), mem_wdata, vecs[v].ewdata);
      chk($sformatf("v%0d busy T", v), busy, 0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("v%0d busy T+1", v), busy, 1);
      chk($sformatf("v%0d owner T+1", v), dbg_owner, vecs[v].eown);
      chk($sformatf("v%0d mem_en T+1", v), mem_en, 0);
      chk($sformatf("v%0d mem_addr T+1", v), mem_addr, 0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d i_rvalid", v), i_rvalid, vecs[v].eown == 2'b01);
      chk($sformatf("v%0d d_rvalid", v), d_rvalid, vecs[v].eown == 2'b10);
      chk($sformatf("v%0d i_rdata", v), i_rdata, (vecs[v].eown == 2'b01) ? vecs[v].erdata : 32'h0);
      chk($sformatf("v%0d d_rdata", v), d_rdata, (vecs[v].eown == 2'b10) ? vecs[v].erdata : 32'h0);
      chk($sformatf("v%0d busy T+2", v), busy, 0);
      chk($sformatf("v%0d owner T+2", v), dbg_owner, 0);
    end

    // ---------------- simultaneous requests ----------------
    @(negedge clk);
    i_req = 1; i_addr = 32'h80; d_req = 1; d_addr = 32'h40; d_be = 4'hF;
    #1;
    chk("sim d_gnt T", d_gnt, 1);
    chk("sim i_gnt T", i_gnt, 0);
    @(negedge clk);
    d_req = 0;
    #1;
    chk("sim owner T+1", dbg_owner, 2'b10);
    chk("sim i_gnt in WAIT", i_gnt, 0);
    @(negedge clk);
    #1;
    chk("sim d_rvalid T+2", d_rvalid, 1);
    chk("sim d_rdata T+2", d_rdata, 32'h0040_FFBF);
    chk("sim i_gnt T+2", i_gnt, 1);
    chk("sim mem_addr T+2", mem_addr, 32'h80);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("sim owner T+3", dbg_owner, 2'b01);
    @(negedge clk);
    #1;
    chk("sim i_rvalid T+4", i_rvalid, 1);
    chk("sim i_rdata T+4", i_rdata, 32'h0080_FF7F);
    chk("sim d_rvalid T+4", d_rvalid, 0);

    // ---------------- streak fairness and throughput ----------------
    wait_cycles(2);
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 1)                   exp_q.push_back(2'b00);
      else if (k == 8 || k == 18)       exp_q.push_back(2'b01);
      else                              exp_q.push_back(2'b10);
    end
    @(negedge clk);
    i_req = 1; i_addr = 32'h10; d_req = 1; d_addr = 32'h40; d_be = 4'hF;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      got = {d_gnt, i_gnt};
      e = exp_q.pop_front();
      chk($sformatf("streak grant c%0d", k), got, e);
    end
    @(negedge clk);
    idle_inputs();
    wait_cycles(6);

    // ---------------- reset during WAIT (MEM_LAT=3) ----------------
    @(negedge clk);
    i_req = 1; i_addr = 32'h10;
    #1;
    chk("abort i_gnt_3 T", i_gnt_3, 1);
    @(negedge clk);
    i_req = 0;
    #1;
    chk("abort busy_3 T+1", busy_3, 1);
    @(negedge clk);
    rst3 = 1;
    d_req = 1; d_addr = 32'h40; d_be = 4'hF;
    #1;
    chk("abort rst d_gnt_3", d_gnt_3, 0);
    chk("abort rst mem_en_3", mem_en_3, 0);
    chk("abort rst mem_addr_3", mem_addr_3, 0);
    chk("abort rst busy_3", busy_3, 0);
    chk("abort rst owner_3", dbg_owner_3, 0);
    chk("abort rst i_rvalid_3", i_rvalid_3, 0);
    @(negedge clk);
    rst3 = 0;
    #1;
    chk("release d_gnt_3", d_gnt_3, 1);
    chk("release mem_en_3", mem_en_3, 1);
    chk("release i_rvalid_3 c3", i_rvalid_3, 0);
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) d_req = 0;
      #1;
      chk($sformatf("release i_rvalid_3 c%0d", k), i_rvalid_3, 0);
      chk($sformatf("release d_rvalid_3 c%0d", k), d_rvalid_3, k == 7);
      if (k == 7) chk("release d_rdata_3", d_rdata_3, 32'h0040_FFBF);
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
